soma_scheduler: RTL and testbench



---
 rtl/soma_scheduler.sv | 171 +++++++++++++++++
 tb/tb_soma_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soma_scheduler.sv
// soma_scheduler
//   Time-step sequencer for the soma datapath and its Vm memory. On each
//   tick_start it sweeps neurons 0..cfg_neuron_last: read Vm, capture the
//   datapath result, write Vm back, and emit a spike token if the neuron
//   fired. While idle it serves single-cycle host accesses to the Vm memory.
//
// Ports
//   clk_soma, rst         clock (rising edge), synchronous active-high reset
//   tick_start            pulse that begins a sweep
//   cfg_neuron_last       highest neuron index to update, sampled at accept
//   busy, tick_done       sweep in progress / one-cycle end-of-sweep pulse
//   tick_overrun          sticky: tick_start seen while busy
//   vm_re/vm_raddr        Vm read port (vm_rdata valid the following cycle)
//   vm_we/vm_waddr/wdata  Vm write port
//   dp_fire, dp_vm_next   datapath result, combinational from vm_rdata
//   spk_vld/addr/rdy      spike token valid/ready port
//   host_*                host Vm access port (req/gnt, rvld/rdata)
module soma_scheduler #(
  parameter int NNW = 12,
  parameter int VW  = 20
) (
  input  logic           clk_soma,
  input  logic           rst,
  input  logic           tick_start,
  input  logic [NNW-1:0] cfg_neuron_last,
  output logic           busy,
  output logic           tick_done,
  output logic           tick_overrun,
  output logic           vm_re,
  output logic [NNW-1:0] vm_raddr,
  input  logic [VW-1:0]  vm_rdata,
  input  logic           dp_fire,
  input  logic [VW-1:0]  dp_vm_next,
  output logic           vm_we,
  output logic [NNW-1:0] vm_waddr,
  output logic [VW-1:0]  vm_wdata,
  output logic           spk_vld,
  output logic [NNW-1:0] spk_addr,
  input  logic           spk_rdy,
  input  logic           host_req,
  input  logic           host_wr,
  input  logic [NNW-1:0] host_addr,
  input  logic [VW-1:0]  host_wdata,
  output logic           host_gnt,
  output logic           host_rvld,
  output logic [VW-1:0]  host_rdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, SPK, DONE} state_t;

  state_t         state, state_nxt;
  logic [NNW-1:0] cnt, cnt_nxt;
  logic [NNW-1:0] last_q, last_nxt;
  logic           fire_q, fire_nxt;
  logic [VW-1:0]  vm_q, vm_nxt;
  logic           busy_nxt;
  logic           spk_vld_nxt;
  logic [NNW-1:0] spk_addr_nxt;
  logic           step;

  always_ff @(posedge clk_soma) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      last_q       <= '0;
      fire_q       <= 1'b0;
      vm_q         <= '0;
      busy         <= 1'b0;
      spk_vld      <= 1'b0;
      spk_addr     <= '0;
      tick_overrun <= 1'b0;
      host_rvld    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      last_q       <= last_nxt;
      fire_q       <= fire_nxt;
      vm_q         <= vm_nxt;
      busy         <= busy_nxt;
      spk_vld      <= spk_vld_nxt;
      spk_addr     <= spk_addr_nxt;
      // busy is still high in DONE, so a tick_start there also counts
      if (tick_start && busy) tick_overrun <= 1'b1;
      host_rvld    <= host_gnt & ~host_wr;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    last_nxt     = last_q;
    fire_nxt     = fire_q;
    vm_nxt       = vm_q;
    busy_nxt     = busy;
    spk_vld_nxt  = spk_vld;
    spk_addr_nxt = spk_addr;
    step         = 1'b0;
    vm_re        = 1'b0;
    vm_raddr     = '0;
    vm_we        = 1'b0;
    vm_waddr     = '0;
    vm_wdata     = '0;
    tick_done    = 1'b0;
    host_gnt     = 1'b0;

    case (state)
      IDLE: begin
        if (tick_start) begin
          cnt_nxt   = '0;
          last_nxt  = cfg_neuron_last;
          busy_nxt  = 1'b1;
          state_nxt = RD;
        end else if (host_req) begin
          host_gnt = 1'b1;
          vm_we    = host_wr;
          vm_re    = ~host_wr;
          vm_waddr = host_addr;
          vm_raddr = host_addr;
          vm_wdata = host_wdata;
        end
      end
      RD: begin
        vm_re     = 1'b1;
        vm_raddr  = cnt;
        state_nxt = CAP;
      end
      CAP: begin
        fire_nxt  = dp_fire;
        vm_nxt    = dp_vm_next;
        state_nxt = WR;
      end
      WR: begin
        vm_we    = 1'b1;
        vm_waddr = cnt;
        vm_wdata = vm_q;
        if (fire_q) begin
          spk_vld_nxt  = 1'b1;
          spk_addr_nxt = cnt;
          state_nxt    = SPK;
        end else begin
          step = 1'b1;
        end
      end
      SPK: begin
        if (spk_rdy) begin
          spk_vld_nxt = 1'b0;
          step        = 1'b1;
        end
      end
      DONE: begin
        tick_done = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Compare before incrementing so a full-range sweep never wraps.
    if (step) begin
      if (cnt == last_q) begin
        state_nxt = DONE;
      end else begin
        cnt_nxt   = cnt + NNW'(1);
        state_nxt = RD;
      end
    end
  end

  assign host_rdata = host_rvld ? vm_rdata : '0;

endmodule

// File: tb/tb_soma_scheduler.sv
module tb_soma_scheduler;
  localparam int NNW = 12;
  localparam int VW  = 20;
  localparam int NN  = 1 << NNW;

  logic           clk_soma = 1'b0;
  logic           rst;
  logic           tick_start;
  logic [NNW-1:0] cfg_neuron_last;
  logic           busy, tick_done, tick_overrun;
  logic           vm_re, vm_we;
  logic [NNW-1:0] vm_raddr, vm_waddr;
  logic [VW-1:0]  vm_rdata, vm_wdata;
  logic           dp_fire;
  logic [VW-1:0]  dp_vm_next;
  logic           spk_vld, spk_rdy;
  logic [NNW-1:0] spk_addr;
  logic           host_req, host_wr, host_gnt, host_rvld;
  logic [NNW-1:0] host_addr;
  logic [VW-1:0]  host_wdata, host_rdata;

  always #5 clk_soma = ~clk_soma;

  soma_scheduler #(.NNW(NNW), .VW(VW)) dut (
    .clk_soma(clk_soma), .rst(rst), .tick_start(tick_start),
    .cfg_neuron_last(cfg_neuron_last), .busy(busy), .tick_done(tick_done),
    .tick_overrun(tick_overrun), .vm_re(vm_re), .vm_raddr(vm_raddr),
    .vm_rdata(vm_rdata), .dp_fire(dp_fire), .dp_vm_next(dp_vm_next),
    .vm_we(vm_we), .vm_waddr(vm_waddr), .vm_wdata(vm_wdata),
    .spk_vld(spk_vld), .spk_addr(spk_addr), .spk_rdy(spk_rdy),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvld(host_rvld),
    .host_rdata(host_rdata)
  );

  int cyc = 0;
  always @(posedge clk_soma) cyc <= cyc + 1;

  // Vm memory (registered read) and datapath: fire on bit VW-1, next = Vm + 0x11
  logic [VW-1:0] mem [NN];
  logic [VW-1:0] rdq = '0;
  always @(posedge clk_soma) begin
    if (vm_re) rdq <= mem[vm_raddr];
    if (vm_we) mem[vm_waddr] <= vm_wdata;
  end
  assign vm_rdata   = rdq;
  assign dp_fire    = rdq[VW-1];
  assign dp_vm_next = rdq + 20'h00011;

  // Scoreboard
  typedef struct { int a; int d; int c; } ev_t;
  typedef struct { int c; int w; int e; } st_t;
  ev_t rd_q[$], wr_q[$], spk_q[$], rvld_q[$];
  int  done_q[$], gnt_q[$];
  st_t st_q[$];
  logic [VW-1:0] shadow [NN];

  int errors = 0, checks = 0;
  int tmo_cnt = 0, tmo_seen = 0;
  bit fin_req = 1'b0;
  int run = 0, first_addr = 0;

  function automatic void push_st(int c, int w, int e);
    st_t s;
    s.c = c; s.w = w; s.e = e;
    st_q.push_back(s);
  endfunction

  function automatic void push_zero(int c);
    for (int w = 0; w < 10; w++) push_st(c, w, 0);
  endfunction

  // Expected events for a sweep started at cycle t0; nstop limits how many
  // neurons are expected (used when the sweep is cut short by reset).
  function automatic int push_sweep(int t0, int last, int stall, int nstop);
    ev_t e;
    int t = t0 + 1;
    for (int i = 0; i <= last && i < nstop; i++) begin
      logic fire = shadow[i][VW-1];
      e.a = i; e.d = 0; e.c = t;       rd_q.push_back(e);
      shadow[i] = shadow[i] + 20'h00011;
      e.d = int'(shadow[i]); e.c = t + 2; wr_q.push_back(e);
      if (fire) begin
        e.d = stall + 1; e.c = 0; spk_q.push_back(e);
        t += 4 + stall;
      end else begin
        t += 3;
      end
    end
    if (nstop > last) done_q.push_back(t);
    return t;
  endfunction

  function automatic void host_push(bit wr, int addr, int data, int c);
    ev_t e;
    gnt_q.push_back(c);
    e.a = addr; e.c = c;
    if (wr) begin
      shadow[addr] = VW'(data);
      e.d = data; wr_q.push_back(e);
    end else begin
      e.d = 0; rd_q.push_back(e);
      e.d = int'(shadow[addr]); e.c = c + 1; rvld_q.push_back(e);
    end
  endfunction

  function automatic int sig_val(int w);
    case (w)
      0: return int'(busy);
      1: return int'(tick_overrun);
      2: return int'(spk_vld);
      3: return int'(vm_we);
      4: return int'(vm_re);
      5: return int'(tick_done);
      6: return int'(host_gnt);
      7: return int'(host_rvld);
      8: return int'(spk_addr);
      default: return int'(host_rdata);
    endcase
  endfunction

  function automatic string sig_name(int w);
    case (w)
      0: return "busy";      1: return "tick_overrun"; 2: return "spk_vld";
      3: return "vm_we";     4: return "vm_re";        5: return "tick_done";
      6: return "host_gnt";  7: return "host_rvld";    8: return "spk_addr";
      default: return "host_rdata";
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Monitor: pops expectations whenever the DUT presents an event
  always @(negedge clk_soma) begin
    ev_t e;
    if (tmo_cnt != tmo_seen) begin
      chk("wait_timeout", tmo_cnt - tmo_seen, 0);
      tmo_seen = tmo_cnt;
    end
    if (cyc > 40000) begin
      chk("global_watchdog", cyc, 40000);
      summary();
    end
    for (int k = st_q.size() - 1; k >= 0; k--) begin
      if (st_q[k].c == cyc) begin
        chk(sig_name(st_q[k].w), sig_val(st_q[k].w), st_q[k].e);
        st_q.delete(k);
      end else if (st_q[k].c < cyc) begin
        chk("stale_state_check", st_q[k].c, cyc);
        st_q.delete(k);
      end
    end
    if (rst) begin
      run = 0;
    end else begin
      if (vm_re) begin
        if (rd_q.size() == 0) chk("read_unexpected", int'(vm_raddr), -1);
        else begin
          e = rd_q.pop_front();
          chk("read_addr", int'(vm_raddr), e.a);
          chk("read_cycle", cyc, e.c);
        end
      end
      if (vm_we) begin
        if (wr_q.size() == 0) chk("write_unexpected", int'(vm_waddr), -1);
        else begin
          e = wr_q.pop_front();
          chk("write_addr", int'(vm_waddr), e.a);
          chk("write_data", int'(vm_wdata), e.d);
          chk("write_cycle", cyc, e.c);
        end
      end
      if (vm_re && vm_we) chk("re_we_same_addr", int'(vm_raddr == vm_waddr), 0);
      if (tick_done) begin
        if (done_q.size() == 0) chk("done_unexpected", cyc, -1);
        else chk("done_cycle", cyc, done_q.pop_front());
      end
      if (host_gnt) begin
        if (gnt_q.size() == 0) chk("gnt_unexpected", cyc, -1);
        else chk("gnt_cycle", cyc, gnt_q.pop_front());
      end
      if (host_rvld) begin
        if (rvld_q.size() == 0) chk("rvld_unexpected", cyc, -1);
        else begin
          e = rvld_q.pop_front();
          chk("host_rdata", int'(host_rdata), e.d);
          chk("rvld_cycle", cyc, e.c);
        end
      end
      if (spk_vld) begin
        run++;
        if (run == 1) first_addr = int'(spk_addr);
        else chk("spk_addr_stable", int'(spk_addr), first_addr);
        if (spk_rdy) begin
          if (spk_q.size() == 0) chk("spike_unexpected", int'(spk_addr), -1);
          else begin
            e = spk_q.pop_front();
            chk("spk_addr", int'(spk_addr), e.a);
            chk("spk_hold_cycles", run, e.d);
          end
          run = 0;
        end
      end
    end
    if (fin_req) begin
      chk("left_reads", rd_q.size(), 0);
      chk("left_writes", wr_q.size(), 0);
      chk("left_spikes", spk_q.size(), 0);
      chk("left_dones", done_q.size(), 0);
      chk("left_grants", gnt_q.size(), 0);
      chk("left_rvld", rvld_q.size(), 0);
      chk("left_state_checks", st_q.size(), 0);
      summary();
    end
  end

  task automatic tick();
    @(posedge clk_soma); #1;
  endtask

  task automatic wait_drain();
    int n;
    for (n = 0; n < 20000; n++) begin
      if (rd_q.size() == 0 && wr_q.size() == 0 && spk_q.size() == 0 &&
          done_q.size() == 0 && gnt_q.size() == 0 && rvld_q.size() == 0 &&
          st_q.size() == 0) break;
      tick();
    end
    if (n == 20000) tmo_cnt++;
  endtask

  task automatic host_wait();
    int n;
    for (n = 0; n < 50; n++) begin
      @(negedge clk_soma);
      if (host_gnt) break;
    end
    if (n == 50) tmo_cnt++;
    tick();
    host_req = 1'b0; host_wr = 1'b0;
  endtask

  task automatic host_op(bit wr, int addr, int data);
    host_push(wr, addr, data, cyc);
    host_req = 1'b1; host_wr = wr; host_addr = NNW'(addr); host_wdata = VW'(data);
    host_wait();
  endtask

  initial begin
    int t0, d, n;
    rst = 1'b1; tick_start = 1'b0; cfg_neuron_last = '0; spk_rdy = 1'b1;
    host_req = 1'b0; host_wr = 1'b0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < NN; i++) begin
      mem[i]    = VW'(i * 16 + 3);
      shadow[i] = VW'(i * 16 + 3);
    end
    repeat (3) @(posedge clk_soma);
    #1 rst = 1'b0;
    push_zero(cyc);

    // Four neurons, no fires: 3 cycles each, done at +13
    tick();
    t0 = cyc; cfg_neuron_last = 12'd3;
    d = push_sweep(t0, 3, 0, NN);
    push_st(t0 + 1, 0, 1); push_st(d, 0, 1); push_st(d + 1, 0, 0);
    tick_start = 1'b1; tick(); tick_start = 1'b0;
    wait_drain();

    // Host write, read-back, then arm neuron 1 to fire
    host_op(1'b1, 5, 20'h12345);
    host_op(1'b0, 5, 0);
    host_op(1'b1, 1, 20'h80020);
    wait_drain();

    // Neuron 1 fires, downstream stalls 5 cycles
    t0 = cyc; cfg_neuron_last = 12'd2; spk_rdy = 1'b0;
    d = push_sweep(t0, 2, 5, NN);
    tick_start = 1'b1; tick(); tick_start = 1'b0;
    while (cyc < t0 + 12) tick();
    spk_rdy = 1'b1;
    wait_drain();

    // tick_start and host_req together: sweep first, grant after done
    t0 = cyc; cfg_neuron_last = 12'd0;
    d = push_sweep(t0, 0, 0, NN);
    host_push(1'b1, 7, 20'hABCDE, d + 1);
    push_st(t0 + 2, 6, 0);
    host_req = 1'b1; host_wr = 1'b1; host_addr = 12'd7; host_wdata = 20'hABCDE;
    tick_start = 1'b1; tick(); tick_start = 1'b0;
    host_wait();
    wait_drain();

    // tick_start re-pulsed mid-sweep
    t0 = cyc; cfg_neuron_last = 12'd3;
    d = push_sweep(t0, 3, 0, NN);
    push_st(t0 + 5, 1, 0); push_st(t0 + 6, 1, 1); push_st(t0 + 6, 0, 1);
    push_st(d + 1, 1, 1); push_st(d + 1, 0, 0);
    tick_start = 1'b1; tick(); tick_start = 1'b0;
    while (cyc < t0 + 5) tick();
    tick_start = 1'b1; tick(); tick_start = 1'b0;
    wait_drain();

    // Reset while a spike is pending
    t0 = cyc; cfg_neuron_last = 12'd2; spk_rdy = 1'b0;
    d = push_sweep(t0, 2, 0, 2);
    tick_start = 1'b1; tick(); tick_start = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk_soma);
      if (spk_vld) break;
    end
    if (n == 40) tmo_cnt++;
    tick();
    rst = 1'b1; spk_q.delete();
    tick();
    rst = 1'b0; spk_rdy = 1'b1;
    push_zero(cyc);
    tick();
    t0 = cyc; cfg_neuron_last = 12'd0;
    d = push_sweep(t0, 0, 0, NN);
    tick_start = 1'b1; tick(); tick_start = 1'b0;
    wait_drain();

    // Full index range: counter stops at the maximum without wrapping
    t0 = cyc; cfg_neuron_last = '1;
    d = push_sweep(t0, NN - 1, 0, NN);
    tick_start = 1'b1; tick(); tick_start = 1'b0;
    wait_drain();
    repeat (4) tick();

    fin_req = 1'b1;
    repeat (5) tick();
  end
endmodule
